// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle sequencer that feeds an 8-bit shift/rotate step circuit.
// Latency: the result is valid (1 + RUN cycles) cycles after the request handshake cycle.
//   RUN takes max(1, ceil(amt/8)) cycles for shifts and 1 cycle for rotates.
// Backpressure: in_ready is low from accept until the result is consumed; DONE holds until out_ready.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready/in_data/
//   in_amt/in_op                     request handshake; in_op = {rot, lr, ar}
//   out_valid/out_ready/out_data     result handshake
//   busy                             high while in RUN or DONE
module shift_sequencer #(
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [7:0]       acc;
  logic [AMT_W-1:0] rem;
  logic [2:0]       op;      // {rot, lr, ar}

  logic [3:0]       step;
  logic [7:0]       shifted;
  logic [15:0]      dbl;

  // At most 8 positions are applied per cycle.
  always_comb begin
    step = (rem > AMT_W'(8)) ? 4'd8 : 4'(rem);
  end

  // Single step of the downstream shift/rotate circuit (n = 0..8).
  // Rotates use a doubled word so that any n in 0..8 wraps correctly;
  // arithmetic right shift fills from a sign-extended upper half.
  always_comb begin
    dbl     = 16'd0;
    shifted = acc;
    if (op[2]) begin
      if (op[1]) begin
        dbl     = {acc, acc} << step;
        shifted = dbl[15:8];
      end else begin
        dbl     = {acc, acc} >> step;
        shifted = dbl[7:0];
      end
    end else if (op[1]) begin
      shifted = acc << step;
    end else if (op[0]) begin
      dbl     = {{8{acc[7]}}, acc} >> step;
      shifted = dbl[7:0];
    end else begin
      shifted = acc >> step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 8'd0;
      rem       <= '0;
      op        <= 3'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= in_data;
            op       <= in_op;
            // A rotate by a multiple of 8 is the identity, so only amt mod 8 matters.
            rem      <= in_op[2] ? AMT_W'(in_amt[2:0]) : in_amt;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // A zero remainder on entry still spends this one cycle with step 0.
          acc <= shifted;
          rem <= rem - AMT_W'(step);
          if (rem == AMT_W'(step)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_amt;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.AMT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the whole operation in one shot, from the operation definitions.
  function automatic int ref_result(input int d, input int amt, input int op);
    int r;
    int v;
    if (op[2]) begin
      r = amt % 8;
      if (op[1]) return ((d << r) | (d >> (8 - r))) & 255;
      else       return ((d >> r) | (d << (8 - r))) & 255;
    end
    if (op[1]) return (amt >= 8) ? 0 : ((d << amt) & 255);
    if (op[0]) begin
      v = (d >= 128) ? d - 256 : d;
      v = v >>> ((amt > 8) ? 8 : amt);
      return v & 255;
    end
    return (amt >= 8) ? 0 : (d >> amt);
  endfunction

  function automatic int ref_cycles(input int amt, input int op);
    if (op[2] || amt == 0) return 1;
    return (amt + 7) / 8;
  endfunction

  // One complete transaction. Called at #1 after a rising edge.
  task automatic run(input string tag, input int d, input int a, input int op,
                     input int hold, input int exp_d, input int exp_c);
    int n;
    logic [7:0] held;
    chk({tag, " in_ready idle"}, in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d[7:0];
    in_amt    = a[7:0];
    in_op     = op[2:0];
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, " accepted"}, {in_ready, busy, out_valid}, 3'b010);
    n = 0;
    while (!out_valid && n < 300) begin
      // Garbage on the inputs must be ignored outside IDLE/DONE.
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_amt    = 8'($urandom);
      in_op     = 3'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " run cycles"}, n, exp_c);
    chk({tag, " result"}, out_data, exp_d);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk({tag, " hold"}, {out_valid, in_ready, busy, out_data}, {3'b101, held});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " released"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    int d, a, op, hold;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_amt = 8'h00;
    in_op = 3'd0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("reset outputs", {out_valid, busy, in_ready, out_data}, {3'b001, 8'h00});

    run("lsl81_1",  8'h81, 1,   3'b010, 0, 8'h02, 1);
    run("asr80_3",  8'h80, 3,   3'b001, 0, 8'hF0, 1);
    run("lsr80_3",  8'h80, 3,   3'b000, 0, 8'h10, 1);
    run("lsl0f_0",  8'h0F, 0,   3'b010, 0, 8'h0F, 1);
    run("lsrff_20", 8'hFF, 20,  3'b000, 0, 8'h00, 3);
    run("asr80_20", 8'h80, 20,  3'b001, 0, 8'hFF, 3);
    run("lsl01_255",8'h01, 255, 3'b010, 0, 8'h00, 32);
    run("rol81_9",  8'h81, 9,   3'b110, 0, 8'h03, 1);
    run("ror01_1",  8'h01, 1,   3'b100, 0, 8'h80, 1);
    run("rora5_8",  8'hA5, 8,   3'b100, 0, 8'hA5, 1);
    run("hold5",    8'h3C, 2,   3'b010, 5, 8'hF0, 1);

    // Reset in the middle of a long shift.
    in_valid = 1'b1; in_data = 8'hFF; in_amt = 8'd40; in_op = 3'b000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid-run busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid-run reset", {out_valid, busy, in_ready, out_data}, {3'b001, 8'h00});
    run("after_rst", 8'hC3, 4, 3'b001, 1, 8'hFC, 1);

    for (int k = 0; k < 60; k++) begin
      d    = int'($urandom_range(0, 255));
      a    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 24));
      op   = int'($urandom_range(0, 7));
      hold = int'($urandom_range(0, 3));
      run($sformatf("rnd%0d", k), d, a, op, hold, ref_result(d, a, op), ref_cycles(a, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
